// File: rtl/bcd_tens_display.sv
// bcd_tens_display: tens digit tracking from units wrap-around, carry/borrow/err flags,
// and a two-digit time-multiplexed 7-segment driver.
module bcd_tens_display #(
    parameter int REFRESH_DIV    = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       x,
    output logic [3:0] tens,
    output logic       carry,
    output logic       borrow,
    output logic       err,
    output logic [6:0] seg,
    output logic [1:0] an
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [3:0]    cur, prev_digit;
    logic          prev_x, primed, sel, up_wrap, dn_wrap, last;
    logic [CW-1:0] cnt;
    logic [6:0]    seg_raw, seg_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    assign cur = {A, B, C, D};
    assign seg = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;

    // A wrap is a 9->0 (up) or 0->9 (down) step seen across two consecutive edges
    always_comb begin
        up_wrap = primed && prev_x && prev_digit == 4'd9 && cur == 4'd0;
        dn_wrap = primed && !prev_x && prev_digit == 4'd0 && cur == 4'd9;
        last    = cnt == CW'(REFRESH_DIV - 1);
        seg_nxt = decode(sel ? tens : cur);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens       <= 4'd0;
            carry      <= 1'b0;
            borrow     <= 1'b0;
            err        <= 1'b0;
            an         <= 2'b00;
            seg_raw    <= 7'h00;
            cnt        <= '0;
            sel        <= 1'b0;
            prev_digit <= 4'd0;
            prev_x     <= 1'b0;
            primed     <= 1'b0;
        end else begin
            prev_digit <= cur;
            prev_x     <= x;
            primed     <= 1'b1;
            err        <= err | (cur > 4'd9);
            carry      <= up_wrap && tens == 4'd9;
            borrow     <= dn_wrap && tens == 4'd0;
            if (up_wrap)
                tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
            else if (dn_wrap)
                tens <= (tens == 4'd0) ? 4'd9 : tens - 4'd1;
            cnt     <= last ? '0 : cnt + 1'b1;
            sel     <= sel ^ last;
            an      <= sel ? 2'b10 : 2'b01;
            seg_raw <= seg_nxt;
        end
    end
endmodule

// File: tb/tb_bcd_tens_display.sv
// tb_bcd_tens_display: directed tests of tens tracking, flags and display mux.
module tb_bcd_tens_display;
    logic       clk = 1'b0, rst = 1'b1, x = 1'b0;
    logic [3:0] u = 4'd0;
    logic [3:0] tens, tens_i;
    logic       carry, borrow, err, carry_i, borrow_i, err_i;
    logic [6:0] seg, seg_i;
    logic [1:0] an, an_i;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    bcd_tens_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .A(u[3]), .B(u[2]), .C(u[1]), .D(u[0]), .x(x),
        .tens(tens), .carry(carry), .borrow(borrow), .err(err), .seg(seg), .an(an));

    bcd_tens_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_i (
        .clk(clk), .rst(rst), .A(u[3]), .B(u[2]), .C(u[1]), .D(u[0]), .x(x),
        .tens(tens_i), .carry(carry_i), .borrow(borrow_i), .err(err_i), .seg(seg_i), .an(an_i));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] d, input logic xv);
        u = d;
        x = xv;
        step();
    endtask

    task automatic wrap_up();
        for (int d = 1; d <= 9; d++) drive(4'(d), 1'b1);
        drive(4'd0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) drive(4'(i * 5 % 16), i[0]);
        checks++;
        if (tens !== 4'd0 || carry !== 1'b0 || borrow !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags tens=%0d carry=%b borrow=%b err=%b required 0/0/0/0", tens, carry, borrow, err);
        end
        checks++;
        if (an !== 2'b00 || seg !== 7'h00 || seg_i !== 7'h7F) begin
            failures++;
            $display("FAIL reset_display an=%b seg=%h seg_i=%h required 00/00/7f", an, seg, seg_i);
        end
        rst = 1'b0;
    endtask

    task automatic test_count_up();
        drive(4'd0, 1'b1);
        for (int d = 1; d <= 9; d++) drive(4'(d), 1'b1);
        checks++;
        if (tens !== 4'd0) begin
            failures++;
            $display("FAIL up_before_wrap tens=%0d required 0", tens);
        end
        drive(4'd0, 1'b1);
        checks++;
        if (tens !== 4'd1 || carry !== 1'b0) begin
            failures++;
            $display("FAIL up_wrap tens=%0d carry=%b required 1/0", tens, carry);
        end
    endtask

    task automatic test_carry();
        repeat (8) wrap_up();
        checks++;
        if (tens !== 4'd9) begin
            failures++;
            $display("FAIL tens_nine tens=%0d required 9", tens);
        end
        wrap_up();
        checks++;
        if (tens !== 4'd0 || carry !== 1'b1 || borrow !== 1'b0) begin
            failures++;
            $display("FAIL carry_pulse tens=%0d carry=%b borrow=%b required 0/1/0", tens, carry, borrow);
        end
        drive(4'd1, 1'b1);
        checks++;
        if (carry !== 1'b0 || tens !== 4'd0) begin
            failures++;
            $display("FAIL carry_end carry=%b tens=%0d required 0/0", carry, tens);
        end
    endtask

    task automatic test_borrow();
        drive(4'd0, 1'b0);
        checks++;
        if (tens !== 4'd0 || borrow !== 1'b0) begin
            failures++;
            $display("FAIL borrow_pre tens=%0d borrow=%b required 0/0", tens, borrow);
        end
        drive(4'd9, 1'b0);
        checks++;
        if (tens !== 4'd9 || borrow !== 1'b1 || carry !== 1'b0) begin
            failures++;
            $display("FAIL borrow_pulse tens=%0d borrow=%b carry=%b required 9/1/0", tens, borrow, carry);
        end
        drive(4'd8, 1'b0);
        checks++;
        if (tens !== 4'd9 || borrow !== 1'b0) begin
            failures++;
            $display("FAIL borrow_end tens=%0d borrow=%b required 9/0", tens, borrow);
        end
    endtask

    task automatic test_invalid();
        int blanks = 0;
        drive(4'd9, 1'b1);
        drive(4'd12, 1'b1);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_set err=%b required 1", err);
        end
        drive(4'd0, 1'b1);
        checks++;
        if (tens !== 4'd9 || carry !== 1'b0) begin
            failures++;
            $display("FAIL invalid_suppress tens=%0d carry=%b required 9/0", tens, carry);
        end
        drive(4'd9, 1'b1);
        drive(4'd0, 1'b1);
        checks++;
        if (tens !== 4'd0 || carry !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL wrap_after_err tens=%0d carry=%b err=%b required 0/1/1", tens, carry, err);
        end
        for (int i = 0; i < 10; i++) begin
            drive(4'd12, 1'b1);
            if (an == 2'b01) begin
                blanks++;
                checks++;
                if (seg !== 7'h00 || seg_i !== 7'h7F) begin
                    failures++;
                    $display("FAIL blank_units seg=%h seg_i=%h required 00/7f", seg, seg_i);
                end
            end
        end
        checks++;
        if (blanks == 0) begin
            failures++;
            $display("FAIL blank_seen count=%0d required >0", blanks);
        end
        drive(4'd5, 1'b1);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky err=%b required 1", err);
        end
    endtask

    task automatic test_display();
        logic [1:0] prev_an;
        int run = 0, changes = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(4'd0, 1'b1);
        repeat (7) wrap_up();
        checks++;
        if (tens !== 4'd7 || err !== 1'b0) begin
            failures++;
            $display("FAIL tens_seven tens=%0d err=%b required 7/0", tens, err);
        end
        drive(4'd3, 1'b1);
        prev_an = an;
        for (int i = 0; i < 20; i++) begin
            drive(4'd3, 1'b1);
            checks++;
            if (!((an === 2'b01 && seg === 7'h4F && seg_i === 7'h30) ||
                  (an === 2'b10 && seg === 7'h07 && seg_i === 7'h78))) begin
                failures++;
                $display("FAIL mux_value an=%b seg=%h seg_i=%h required 01/4f/30 or 10/07/78", an, seg, seg_i);
            end
            if (an === prev_an) run++;
            else begin
                if (changes > 0) begin
                    checks++;
                    if (run != 4) begin
                        failures++;
                        $display("FAIL mux_period run=%0d required 4", run);
                    end
                end
                changes++;
                run = 1;
            end
            prev_an = an;
        end
        checks++;
        if (changes < 3) begin
            failures++;
            $display("FAIL mux_toggles changes=%0d required >=3", changes);
        end
    endtask

    task automatic test_reset_release();
        drive(4'd9, 1'b1);
        rst = 1'b1;
        step();
        u = 4'd0;
        x = 1'b1;
        rst = 1'b0;
        step();
        checks++;
        if (tens !== 4'd0 || carry !== 1'b0) begin
            failures++;
            $display("FAIL reset_release tens=%0d carry=%b required 0/0", tens, carry);
        end
        drive(4'd1, 1'b1);
        checks++;
        if (tens !== 4'd0 || carry !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_after tens=%0d carry=%b required 0/0", tens, carry);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_carry();
        test_borrow();
        test_invalid();
        test_display();
        test_reset_release();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
